// File: rtl/not_gate_rr_scheduler.sv
// not_gate_rr_scheduler
//   Round-robin front end for one shared WIDTH-bit bitwise inverter. NUM_REQ
//   requesters offer operands over valid/ready; the winner's operand is inverted
//   into a single-entry result register tagged with the requester index, which
//   drains over a valid/ready response port.
//
// Ports
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   REQ_VALID  [NUM_REQ]        requester i has an operand
//   REQ_DATA   [NUM_REQ*WIDTH]  operand i in bits [i*WIDTH +: WIDTH]
//   REQ_READY  [NUM_REQ]        one-hot-or-zero accept strobe
//   RSP_VALID                   result register holds a result
//   RSP_READY                   downstream consumes the result this cycle
//   RSP_DATA   [WIDTH]          inverted operand
//   RSP_ID     [ID_W]           index of the producing requester
module not_gate_rr_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ_VALID,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       REQ_READY,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [WIDTH-1:0]         RSP_DATA,
    output logic [ID_W-1:0]          RSP_ID
);

    logic [NUM_REQ-1:0][WIDTH-1:0] req_data_a;
    logic [ID_W-1:0]               ptr;
    logic [ID_W-1:0]               grant_idx;
    logic [ID_W-1:0]               ptr_nxt;
    logic                          grant_vld;
    logic                          slot_free;
    logic                          accept;

    assign req_data_a = REQ_DATA;

    // The register can take a new result when empty or when it drains this cycle.
    assign slot_free = !RSP_VALID || RSP_READY;

    // Circular priority search starting at ptr. The grant depends only on
    // REQ_VALID and ptr, never on operand data.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!grant_vld && REQ_VALID[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ready is suppressed while reset is held so nothing looks accepted.
    always_comb begin
        REQ_READY = '0;
        if (!RST && slot_free && grant_vld) REQ_READY[grant_idx] = 1'b1;
    end

    assign accept  = |REQ_READY;
    assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Accept has priority over drain so a simultaneous drain+accept leaves no bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ID    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= ~req_data_a[grant_idx];
            RSP_ID    <= grant_idx;
            ptr       <= ptr_nxt;
        end else if (RSP_READY) begin
            // Drain only; data and id keep their last values.
            RSP_VALID <= 1'b0;
        end
    end

endmodule
